aux_unpack: RTL and testbench
=============================

Name: aux_unpack

Overview:
- Downstream consumer of the receiver's AUX FIFO.
- Pops 24-bit aux words, each {hdr[11:0], payload[11:0]}. Reverses the receiver's 3-bytes-into-2-words packing and emits a byte stream, framed per audio block, with valid/ready backpressure.
- Feeds the audio/data-island packetizer. Checks header consistency and counts blocks.

Parameters:
- WORDS_PER_BLK, 32, payload words per audio block; must be even. 32 words = 48 bytes.
- CNT_W, 16, width of the block counter.

Ports:
- clk125  in  1  system clock; all logic on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- fifo_dout  in  24  AUX FIFO read data; valid one cycle after fifo_rd_en (standard, non-FWFT FIFO).
- fifo_empty  in  1  AUX FIFO empty.
- fifo_rd_en  out  1  AUX FIFO read strobe.
- byte_data  out  8  unpacked byte.
- byte_valid  out  1  byte_data valid.
- byte_ready  in  1  downstream accepts; a transfer happens when byte_valid && byte_ready.
- byte_sop  out  1  first byte of a block; qualified by byte_valid.
- byte_eop  out  1  last byte of a block; qualified by byte_valid.
- blk_id  out  8  hdr[7:0] latched from the block's first word.
- blk_left  out  4  hdr[11:8] latched from the block's first word.
- hdr_err  out  1  one-cycle pulse on header mismatch.
- blk_cnt  out  CNT_W  blocks completed (eop transferred); wraps.

Behaviour:
- Reset values: all outputs 0; FSM in S_RDA; word counter 0; latched header 0.
- Clock and reset: one clock (clk125); sys_rst_n is asynchronous and active-low. Reset mid-operation aborts the block silently; no eop is emitted for it.
- Word pair: A then B. Bytes are formed as:
  - b0 = A[7:0]
  - b1 = {B[3:0], A[11:8]}
  - b2 = B[11:4]
- FSM states and transitions:
  - S_RDA: fifo_rd_en = !fifo_empty. On the read, go to S_CAPA.
  - S_CAPA: capture A. If word counter == 0, latch hdr into blk_id/blk_left. Go to S_RDB.
  - S_RDB: fifo_rd_en = !fifo_empty. On the read, go to S_CAPB.
  - S_CAPB: capture B. Go to S_E0.
  - S_E0: present b0. On transfer go to S_E1.
  - S_E1: present b1. On transfer go to S_E2.
  - S_E2: present b2. On transfer: word counter += 2. If it reaches WORDS_PER_BLK, clear it and go to S_RDA. Otherwise go to S_RDA.
- fifo_rd_en is asserted only in S_RDA/S_RDB and only when !fifo_empty. Never read while empty; never read while a byte is pending.
- Latency: byte_valid rises 1 cycle after the B capture cycle. Best case is 4 cycles from the A read strobe to b0 valid.
- byte_valid is high in S_E0..S_E2. While byte_valid && !byte_ready, byte_data/sop/eop hold stable.
- byte_sop = 1 in S_E0 when word counter == 0.
- byte_eop = 1 in S_E2 when word counter + 2 == WORDS_PER_BLK.
- Header check: every captured word with word counter != 0 must carry hdr equal to the latched header. On mismatch:
  - pulse hdr_err;
  - discard the current pair;
  - set word counter to 0;
  - the mismatched word starts a new block: when it is an A word, it becomes word A of the new block (latch its hdr, go to S_RDB); when it is a B word, discard it and go to S_RDA.
  - The aborted block gets no eop, and blk_cnt does not increment.
- blk_cnt increments on the eop transfer; it wraps from 2^CNT_W-1 to 0.
- fifo_empty during S_RDA/S_RDB: wait indefinitely. No timeout; state is held.
- Simultaneous eop transfer and non-empty FIFO: the next A read occurs the following cycle (S_RDA). No bubble-free overlap is required.

Decomposition:
- Shared package aux_pkg holds:
  - AUX_HDR_W = 12, AUX_PAY_W = 12;
  - state encoding S_RDA..S_E2 (3 bits);
  - default WORDS_PER_BLK = 32.
- One natural sub-module: aux_pair2bytes. It is combinational: A, B and a 2-bit select in, byte out. It implements the b0/b1/b2 mapping so the bench can reuse it as the reference model.

Test Plan:
- Single block, byte_ready=1: 32 words with hdr=12'h1A5 encoding bytes 0x00..0x2F -> 48 bytes 0x00..0x2F in order; sop on 0x00, eop on 0x2F; blk_id=0xA5, blk_left=1; blk_cnt=1; hdr_err never asserted.
- Backpressure: same block, byte_ready toggles 1,0,0,1 -> byte stream identical to the previous case; data/sop/eop stable across stalls; no FIFO read while any byte is pending.
- Empty gaps: fifo_empty asserted for 5 cycles between A and B of pair 7 -> fifo_rd_en low throughout the gap; output identical to the first case.
- Header mismatch: word 10 (an A word) carries hdr=12'h2A6 -> one hdr_err pulse; no eop for block 1; word 10 starts a new block with blk_id=0xA6; that block completes after 32 words; blk_cnt=1.
- Reset mid-block: sys_rst_n low after 20 bytes -> all outputs 0 immediately (asynchronous); after release, the next 32 words form a clean block with sop on its first byte.
- Counter wrap with CNT_W=2: 5 back-to-back blocks -> blk_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/aux_pkg.sv
// Shared widths and FSM encoding for the AUX FIFO unpacker.
package aux_pkg;

    localparam int AUX_HDR_W         = 12;
    localparam int AUX_PAY_W         = 12;
    localparam int AUX_WORD_W        = AUX_HDR_W + AUX_PAY_W;
    localparam int DEF_WORDS_PER_BLK = 32;

    localparam logic [2:0] S_RDA  = 3'd0;
    localparam logic [2:0] S_CAPA = 3'd1;
    localparam logic [2:0] S_RDB  = 3'd2;
    localparam logic [2:0] S_CAPB = 3'd3;
    localparam logic [2:0] S_E0   = 3'd4;
    localparam logic [2:0] S_E1   = 3'd5;
    localparam logic [2:0] S_E2   = 3'd6;

endpackage

// File: rtl/aux_pair2bytes.sv
// Combinational unpack of one A/B payload pair into one of its three bytes.
module aux_pair2bytes
    import aux_pkg::*;
(
    input  logic [AUX_PAY_W-1:0] a,
    input  logic [AUX_PAY_W-1:0] b,
    input  logic [1:0]           sel,
    output logic [7:0]           byte_o
);

    always_comb begin
        case (sel)
            2'd0:    byte_o = a[7:0];
            2'd1:    byte_o = {b[3:0], a[11:8]};
            default: byte_o = b[11:4];
        endcase
    end

endmodule

// File: rtl/aux_unpack.sv
// Pops {hdr,payload} words from the AUX FIFO in A/B pairs and streams the
// three packed bytes per pair with block framing and header checking.
module aux_unpack
    import aux_pkg::*;
#(
    parameter int WORDS_PER_BLK = DEF_WORDS_PER_BLK,
    parameter int CNT_W         = 16
) (
    input  logic             clk125,
    input  logic             sys_rst_n,
    input  logic [23:0]      fifo_dout,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic [7:0]       byte_data,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             byte_sop,
    output logic             byte_eop,
    output logic [7:0]       blk_id,
    output logic [3:0]       blk_left,
    output logic             hdr_err,
    output logic [CNT_W-1:0] blk_cnt
);

    localparam int WC_W = $clog2(WORDS_PER_BLK) + 1;

    logic [2:0]           state_q, state_d;
    logic [WC_W-1:0]      wcnt_q, wcnt_d;
    logic [AUX_PAY_W-1:0] a_q, a_d, b_q, b_d;
    logic [AUX_HDR_W-1:0] hdr_q, hdr_d;
    logic                 hdr_err_q, hdr_err_d;
    logic [CNT_W-1:0]     blk_cnt_q, blk_cnt_d;

    logic [AUX_HDR_W-1:0] in_hdr;
    logic [AUX_PAY_W-1:0] in_pay;
    logic                 hdr_bad;
    logic                 xfer;
    logic                 last_pair;
    logic [1:0]           sel;
    logic [7:0]           pair_byte;

    assign in_hdr    = fifo_dout[AUX_WORD_W-1:AUX_PAY_W];
    assign in_pay    = fifo_dout[AUX_PAY_W-1:0];
    // The first pair of a block is never checked: its header is the reference.
    assign hdr_bad   = (wcnt_q != '0) && (in_hdr != hdr_q);
    assign last_pair = (wcnt_q + WC_W'(2)) == WC_W'(WORDS_PER_BLK);

    assign byte_valid = (state_q == S_E0) || (state_q == S_E1) || (state_q == S_E2);
    assign xfer       = byte_valid && byte_ready;
    assign fifo_rd_en = ((state_q == S_RDA) || (state_q == S_RDB)) && !fifo_empty;

    always_comb begin
        case (state_q)
            S_E0:    sel = 2'd0;
            S_E1:    sel = 2'd1;
            default: sel = 2'd2;
        endcase
    end

    aux_pair2bytes u_p2b (
        .a      (a_q),
        .b      (b_q),
        .sel    (sel),
        .byte_o (pair_byte)
    );

    assign byte_data = byte_valid ? pair_byte : 8'h00;
    assign byte_sop  = (state_q == S_E0) && (wcnt_q == '0);
    assign byte_eop  = (state_q == S_E2) && last_pair;
    assign blk_id    = hdr_q[7:0];
    assign blk_left  = hdr_q[11:8];
    assign hdr_err   = hdr_err_q;
    assign blk_cnt   = blk_cnt_q;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        a_d       = a_q;
        b_d       = b_q;
        hdr_d     = hdr_q;
        hdr_err_d = 1'b0;
        blk_cnt_d = blk_cnt_q;
        case (state_q)
            S_RDA: if (!fifo_empty) state_d = S_CAPA;
            S_CAPA: begin
                a_d     = in_pay;
                state_d = S_RDB;
                if (wcnt_q == '0) begin
                    hdr_d = in_hdr;
                end else if (hdr_bad) begin
                    // Mismatched A word restarts as word A of a fresh block.
                    hdr_err_d = 1'b1;
                    wcnt_d    = '0;
                    hdr_d     = in_hdr;
                end
            end
            S_RDB: if (!fifo_empty) state_d = S_CAPB;
            S_CAPB: begin
                b_d     = in_pay;
                state_d = S_E0;
                if (hdr_bad) begin
                    hdr_err_d = 1'b1;
                    wcnt_d    = '0;
                    state_d   = S_RDA;
                end
            end
            S_E0: if (xfer) state_d = S_E1;
            S_E1: if (xfer) state_d = S_E2;
            S_E2: begin
                if (xfer) begin
                    state_d = S_RDA;
                    if (last_pair) begin
                        wcnt_d    = '0;
                        blk_cnt_d = blk_cnt_q + CNT_W'(1);
                    end else begin
                        wcnt_d = wcnt_q + WC_W'(2);
                    end
                end
            end
            default: state_d = S_RDA;
        endcase
    end

    always_ff @(posedge clk125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= S_RDA;
            wcnt_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            hdr_q     <= '0;
            hdr_err_q <= 1'b0;
            blk_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            hdr_q     <= hdr_d;
            hdr_err_q <= hdr_err_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

endmodule

// File: tb/tb_aux_unpack.sv
// Directed bench for aux_unpack: FIFO model, byte collector and per-scenario tasks.
module tb_aux_unpack;

    logic        clk125 = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [23:0] fifo_dout = '0;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready = 1'b1;
    logic        byte_sop, byte_eop;
    logic [7:0]  blk_id;
    logic [3:0]  blk_left;
    logic        hdr_err;
    logic [1:0]  blk_cnt;

    int n_chk = 0;
    int n_fail = 0;

    aux_unpack #(.WORDS_PER_BLK(32), .CNT_W(2)) dut (
        .clk125     (clk125),
        .sys_rst_n  (sys_rst_n),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_sop   (byte_sop),
        .byte_eop   (byte_eop),
        .blk_id     (blk_id),
        .blk_left   (blk_left),
        .hdr_err    (hdr_err),
        .blk_cnt    (blk_cnt)
    );

    always #4 clk125 = ~clk125;

    // FIFO model: non-FWFT, optional forced-empty gap in front of word gap_at.
    logic [23:0] words [0:1023];
    int wr_ptr = 0, rd_ptr = 0;
    int gap_at = -1, gap_len = 0, gap_cnt = 0, gap_seen = 0;

    assign fifo_empty = (rd_ptr >= wr_ptr) || ((rd_ptr == gap_at) && (gap_cnt < gap_len));

    always @(posedge clk125) begin
        if (fifo_rd_en) begin
            fifo_dout <= words[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
        if (rd_ptr == gap_at && gap_cnt < gap_len) begin
            gap_cnt  <= gap_cnt + 1;
            gap_seen <= gap_seen + 1;
        end else if (rd_ptr != gap_at) begin
            gap_cnt <= 0;
        end
    end

    // Collector and protocol monitors.
    logic [7:0] col_data [0:1023];
    logic       col_sop  [0:1023];
    logic       col_eop  [0:1023];
    int col_n = 0, stab_err = 0, pend_err = 0, empty_err = 0, herr_n = 0;
    logic        stall_prev = 1'b0;
    logic [10:0] stall_snap = '0;

    always @(posedge clk125) begin
        if (stall_prev && ({byte_valid, byte_sop, byte_eop, byte_data} !== stall_snap))
            stab_err = stab_err + 1;
        stall_prev = byte_valid && !byte_ready;
        stall_snap = {byte_valid, byte_sop, byte_eop, byte_data};
        if (fifo_rd_en && byte_valid) pend_err = pend_err + 1;
        if (fifo_rd_en && fifo_empty) empty_err = empty_err + 1;
        if (hdr_err) herr_n = herr_n + 1;
        if (byte_valid && byte_ready) begin
            col_data[col_n] = byte_data;
            col_sop[col_n]  = byte_sop;
            col_eop[col_n]  = byte_eop;
            col_n = col_n + 1;
        end
    end

    logic [1:0] cnt_hist [0:63];
    int   hist_n = 0;
    logic [1:0] cnt_last = 2'd0;
    always @(negedge clk125) begin
        if (blk_cnt !== cnt_last) begin
            cnt_hist[hist_n] = blk_cnt;
            hist_n = hist_n + 1;
        end
        cnt_last = blk_cnt;
    end

    // byte_ready pattern 1,0,0,1 when backpressure is enabled.
    bit bp_mode = 1'b0;
    int bp_ph = 0;
    always @(negedge clk125) begin
        if (bp_mode) begin
            byte_ready = (bp_ph == 0) || (bp_ph == 3);
            bp_ph = (bp_ph + 1) % 4;
        end else begin
            byte_ready = 1'b1;
        end
    end

    task automatic load_block(input logic [11:0] hdr, input logic [7:0] start, input int nwords);
        logic [7:0] b0, b1, b2;
        for (int p = 0; p < nwords / 2; p++) begin
            b0 = start + 8'(3 * p);
            b1 = b0 + 8'd1;
            b2 = b0 + 8'd2;
            words[wr_ptr]     = {hdr, b1[3:0], b0};
            words[wr_ptr + 1] = {hdr, b2, b1[7:4]};
            wr_ptr = wr_ptr + 2;
        end
    endtask

    task automatic wait_bytes(input int target, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (col_n >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk125);
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) @(negedge clk125);
        n_chk++;
        if ({fifo_rd_en, byte_valid, byte_data, byte_sop, byte_eop} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_stream: got %h want 000", {fifo_rd_en, byte_valid, byte_data, byte_sop, byte_eop});
        end
        n_chk++;
        if ({blk_id, blk_left, hdr_err} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_hdr: got %h want 0", {blk_id, blk_left, hdr_err});
        end
        n_chk++;
        if (blk_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d want 0", blk_cnt);
        end
        sys_rst_n = 1'b1;
        @(negedge clk125);
    endtask

    task automatic test_single_block();
        int base, herr0, lat;
        bit ok;
        logic [9:0] exp, got;
        base = col_n;
        herr0 = herr_n;
        load_block(12'h1A5, 8'h00, 32);
        #1;
        for (int c = 0; c < 50 && !fifo_rd_en; c++) @(negedge clk125);
        lat = 0;
        while (!byte_valid && lat < 50) begin
            @(negedge clk125);
            lat++;
        end
        n_chk++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL single_latency: got %0d want 4", lat);
        end
        wait_bytes(base + 48, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_timeout: got %0d bytes want 48", col_n - base);
        end
        repeat (10) @(negedge clk125);
        n_chk++;
        if (col_n - base != 48) begin
            n_fail++;
            $display("FAIL single_count: got %0d want 48", col_n - base);
        end
        for (int i = 0; i < 48; i++) begin
            exp = {i == 0, i == 47, 8'(i)};
            got = {col_sop[base + i], col_eop[base + i], col_data[base + i]};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL single_byte[%0d]: got %h want %h", i, got, exp);
            end
        end
        n_chk++;
        if ({blk_id, blk_left, blk_cnt} !== {8'hA5, 4'h1, 2'd1}) begin
            n_fail++;
            $display("FAIL single_hdr_cnt: got %h/%h/%0d want a5/1/1", blk_id, blk_left, blk_cnt);
        end
        n_chk++;
        if (herr_n != herr0) begin
            n_fail++;
            $display("FAIL single_hdr_err: got %0d pulses want 0", herr_n - herr0);
        end
    endtask

    task automatic test_backpressure();
        int base, stab0, pend0;
        bit ok;
        logic [9:0] exp, got;
        base = col_n;
        stab0 = stab_err;
        pend0 = pend_err;
        bp_mode = 1'b1;
        load_block(12'h1A5, 8'h00, 32);
        wait_bytes(base + 48, ok);
        bp_mode = 1'b0;
        repeat (10) @(negedge clk125);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_timeout: got %0d bytes want 48", col_n - base);
        end
        for (int i = 0; i < 48; i++) begin
            exp = {i == 0, i == 47, 8'(i)};
            got = {col_sop[base + i], col_eop[base + i], col_data[base + i]};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL bp_byte[%0d]: got %h want %h", i, got, exp);
            end
        end
        n_chk++;
        if (stab_err != stab0) begin
            n_fail++;
            $display("FAIL bp_stable: got %0d unstable stalls want 0", stab_err - stab0);
        end
        n_chk++;
        if (pend_err != pend0) begin
            n_fail++;
            $display("FAIL bp_read_pending: got %0d reads want 0", pend_err - pend0);
        end
        n_chk++;
        if (blk_cnt !== 2'd2) begin
            n_fail++;
            $display("FAIL bp_cnt: got %0d want 2", blk_cnt);
        end
    endtask

    task automatic test_empty_gap();
        int base, empty0, seen0;
        bit ok;
        logic [9:0] exp, got;
        base = col_n;
        empty0 = empty_err;
        seen0 = gap_seen;
        gap_at = wr_ptr + 15;
        gap_len = 5;
        load_block(12'h1A5, 8'h00, 32);
        wait_bytes(base + 48, ok);
        repeat (10) @(negedge clk125);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL gap_timeout: got %0d bytes want 48", col_n - base);
        end
        n_chk++;
        if (gap_seen - seen0 != 5) begin
            n_fail++;
            $display("FAIL gap_len: got %0d empty cycles want 5", gap_seen - seen0);
        end
        n_chk++;
        if (empty_err != empty0) begin
            n_fail++;
            $display("FAIL gap_read_empty: got %0d reads want 0", empty_err - empty0);
        end
        for (int i = 0; i < 48; i++) begin
            exp = {i == 0, i == 47, 8'(i)};
            got = {col_sop[base + i], col_eop[base + i], col_data[base + i]};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL gap_byte[%0d]: got %h want %h", i, got, exp);
            end
        end
        n_chk++;
        if (blk_cnt !== 2'd3) begin
            n_fail++;
            $display("FAIL gap_cnt: got %0d want 3", blk_cnt);
        end
    endtask

    task automatic test_hdr_mismatch();
        int base, herr0;
        bit ok;
        logic [9:0] exp, got;
        base = col_n;
        herr0 = herr_n;
        load_block(12'h1A5, 8'h00, 10);
        load_block(12'h2A6, 8'h40, 32);
        wait_bytes(base + 63, ok);
        repeat (10) @(negedge clk125);
        n_chk++;
        if (!ok || col_n - base != 63) begin
            n_fail++;
            $display("FAIL mis_count: got %0d bytes want 63", col_n - base);
        end
        for (int i = 0; i < 15; i++) begin
            exp = {i == 0, 1'b0, 8'(i)};
            got = {col_sop[base + i], col_eop[base + i], col_data[base + i]};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL mis_abort_byte[%0d]: got %h want %h", i, got, exp);
            end
        end
        for (int j = 0; j < 48; j++) begin
            exp = {j == 0, j == 47, 8'(8'h40 + j)};
            got = {col_sop[base + 15 + j], col_eop[base + 15 + j], col_data[base + 15 + j]};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL mis_new_byte[%0d]: got %h want %h", j, got, exp);
            end
        end
        n_chk++;
        if (herr_n - herr0 != 1) begin
            n_fail++;
            $display("FAIL mis_hdr_err: got %0d pulses want 1", herr_n - herr0);
        end
        n_chk++;
        if ({blk_id, blk_left, blk_cnt} !== {8'hA6, 4'h2, 2'd0}) begin
            n_fail++;
            $display("FAIL mis_hdr_cnt: got %h/%h/%0d want a6/2/0", blk_id, blk_left, blk_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        bit ok;
        logic [9:0] exp, got;
        base = col_n;
        load_block(12'h1A5, 8'h00, 32);
        for (int c = 0; c < 1000 && col_n - base < 20; c++) @(negedge clk125);
        sys_rst_n = 1'b0;
        wr_ptr = rd_ptr;
        #1;
        n_chk++;
        if ({fifo_rd_en, byte_valid, byte_data, byte_sop, byte_eop, hdr_err} !== 13'h0) begin
            n_fail++;
            $display("FAIL mid_rst_stream: got %h want 0", {fifo_rd_en, byte_valid, byte_data, byte_sop, byte_eop, hdr_err});
        end
        n_chk++;
        if ({blk_id, blk_left, blk_cnt} !== 14'h0) begin
            n_fail++;
            $display("FAIL mid_rst_hdr_cnt: got %h want 0", {blk_id, blk_left, blk_cnt});
        end
        @(negedge clk125);
        sys_rst_n = 1'b1;
        @(negedge clk125);
        base = col_n;
        load_block(12'h1A5, 8'h80, 32);
        wait_bytes(base + 48, ok);
        repeat (10) @(negedge clk125);
        n_chk++;
        if (!ok || col_n - base != 48) begin
            n_fail++;
            $display("FAIL mid_count: got %0d bytes want 48", col_n - base);
        end
        for (int i = 0; i < 48; i++) begin
            exp = {i == 0, i == 47, 8'(8'h80 + i)};
            got = {col_sop[base + i], col_eop[base + i], col_data[base + i]};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL mid_byte[%0d]: got %h want %h", i, got, exp);
            end
        end
        n_chk++;
        if (blk_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL mid_cnt: got %0d want 1", blk_cnt);
        end
    endtask

    task automatic test_cnt_wrap();
        int hbase, base;
        bit ok;
        logic [1:0] exp_seq [0:4];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        sys_rst_n = 1'b0;
        repeat (2) @(negedge clk125);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge clk125);
        hbase = hist_n;
        base = col_n;
        for (int k = 0; k < 5; k++) load_block(12'h1A5, 8'h00, 32);
        wait_bytes(base + 240, ok);
        repeat (10) @(negedge clk125);
        n_chk++;
        if (!ok || hist_n - hbase != 5) begin
            n_fail++;
            $display("FAIL wrap_events: got %0d changes want 5", hist_n - hbase);
        end
        for (int k = 0; k < 5; k++) begin
            n_chk++;
            if (cnt_hist[hbase + k] !== exp_seq[k]) begin
                n_fail++;
                $display("FAIL wrap_seq[%0d]: got %0d want %0d", k, cnt_hist[hbase + k], exp_seq[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_backpressure();
        test_empty_gap();
        test_hdr_mismatch();
        test_reset_mid();
        test_cnt_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
